// File: rtl/fpdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_ctrl
//  Purpose  : Sequencing FSM for the Goldschmidt single-precision divider.
//             Walks the datapath through the initial-approximation multiplies,
//             ITERS refinement iterations (numerator step + denominator step)
//             and the final remainder multiply, with a start/busy/done
//             handshake towards the issuing FP unit.
//  Ports    : clk, reset (async, active-low)
//             start, abort           - handshake / cancel inputs
//             stall                  - only with FPDIV_CTRL_STALL_EN defined
//             en_a, en_b, en_rem     - datapath register load enables
//             sel_mux3, sel_mux4     - multiplier operand selects
//             busy, done, iter_cnt   - status / observation
//  Options  : FPDIV_CTRL_STALL_EN adds the stall input (freeze while busy).
//  Revision : 1.0 - initial release
// ============================================================================
module fpdiv_ctrl #(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
`ifdef FPDIV_CTRL_STALL_EN
    input  logic       stall,
`endif
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       busy,
    output logic       done,
    output logic [3:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_N = 3'd1,
        S_INIT_D = 3'd2,
        S_ITER_N = 3'd3,
        S_ITER_D = 3'd4,
        S_REM    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Index of the last refinement iteration; clamped so ITERS = 0 stays legal.
    localparam int         c_LAST_INT  = (ITERS > 0) ? ITERS - 1 : 0;
    localparam logic [3:0] c_LAST      = c_LAST_INT[3:0];
    localparam logic       c_HAS_ITERS = (ITERS > 0);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_iter_cnt;
    logic [3:0] w_iter_next;

    logic       r_en_a;
    logic       r_en_b;
    logic       r_en_rem;
    logic [1:0] r_sel_mux3;
    logic [1:0] r_sel_mux4;
    logic       r_busy;
    logic       r_done;

    logic       w_stall;
    logic       w_busy_st;
    logic       w_hold;

`ifdef FPDIV_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_busy_st = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_hold    = w_stall & w_busy_st;

    // Next-state / next-iteration logic. abort beats stall, stall beats advance.
    always_comb begin
        w_next      = r_state;
        w_iter_next = r_iter_cnt;
        if ((r_state != S_IDLE) && abort) begin
            w_next      = S_IDLE;
            w_iter_next = 4'd0;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next      = S_INIT_N;
                        w_iter_next = 4'd0;
                    end
                end
                S_INIT_N: w_next = S_INIT_D;
                S_INIT_D: w_next = c_HAS_ITERS ? S_ITER_N : S_REM;
                S_ITER_N: w_next = S_ITER_D;
                S_ITER_D: begin
                    if (r_iter_cnt < c_LAST) begin
                        w_next      = S_ITER_N;
                        w_iter_next = r_iter_cnt + 4'd1;
                    end else begin
                        w_next = S_REM;
                    end
                end
                S_REM: w_next = S_DONE;
                S_DONE: begin
                    if (start) begin
                        w_next      = S_INIT_N;
                        w_iter_next = 4'd0;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next      = S_IDLE;
                    w_iter_next = 4'd0;
                end
            endcase
        end
    end

    // State register plus outputs decoded from the next state, so every output
    // comes straight from a flop and still reflects the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= 4'd0;
            r_en_a     <= 1'b0;
            r_en_b     <= 1'b0;
            r_en_rem   <= 1'b0;
            r_sel_mux3 <= 2'd0;
            r_sel_mux4 <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_iter_cnt <= w_iter_next;
            r_en_a     <= 1'b0;
            r_en_b     <= 1'b0;
            r_en_rem   <= 1'b0;
            r_sel_mux3 <= 2'd0;
            r_sel_mux4 <= 2'd0;
            r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            case (w_next)
                S_INIT_N: begin
                    r_en_a <= 1'b1;
                end
                S_INIT_D: begin
                    r_en_b     <= 1'b1;
                    r_sel_mux4 <= 2'd1;
                end
                S_ITER_N: begin
                    r_en_a     <= 1'b1;
                    r_sel_mux3 <= 2'd1;
                    r_sel_mux4 <= 2'd2;
                end
                S_ITER_D: begin
                    r_en_b     <= 1'b1;
                    r_sel_mux3 <= 2'd1;
                    r_sel_mux4 <= 2'd3;
                end
                S_REM: begin
                    r_en_rem   <= 1'b1;
                    r_sel_mux3 <= 2'd2;
                    r_sel_mux4 <= 2'd2;
                end
                default: begin
                end
            endcase
        end
    end

    // A stalled cycle must not load any datapath register; selects stay put.
    assign en_a     = r_en_a   & ~w_hold;
    assign en_b     = r_en_b   & ~w_hold;
    assign en_rem   = r_en_rem & ~w_hold;
    assign sel_mux3 = r_sel_mux3;
    assign sel_mux4 = r_sel_mux4;
    assign busy     = r_busy;
    assign done     = r_done;
    assign iter_cnt = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_ctrl
//  Purpose  : Self-checking bench for fpdiv_ctrl (ITERS = 3 and ITERS = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpdiv_ctrl;

    localparam int ST_IDLE   = 0;
    localparam int ST_INIT_N = 1;
    localparam int ST_INIT_D = 2;
    localparam int ST_ITER_N = 3;
    localparam int ST_ITER_D = 4;
    localparam int ST_REM    = 5;
    localparam int ST_DONE   = 6;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       start0 = 1'b0;
`ifdef FPDIV_CTRL_STALL_EN
    logic       stall  = 1'b0;
`endif

    logic       en_a, en_b, en_rem, busy, done;
    logic [1:0] sel_mux3, sel_mux4;
    logic [3:0] iter_cnt;

    logic       z_en_a, z_en_b, z_en_rem, z_busy, z_done;
    logic [1:0] z_sel_mux3, z_sel_mux4;
    logic [3:0] z_iter_cnt;

    fpdiv_ctrl #(.ITERS(3)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
`ifdef FPDIV_CTRL_STALL_EN
        .stall    (stall),
`endif
        .en_a     (en_a),
        .en_b     (en_b),
        .en_rem   (en_rem),
        .sel_mux3 (sel_mux3),
        .sel_mux4 (sel_mux4),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    fpdiv_ctrl #(.ITERS(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .start    (start0),
        .abort    (1'b0),
`ifdef FPDIV_CTRL_STALL_EN
        .stall    (1'b0),
`endif
        .en_a     (z_en_a),
        .en_b     (z_en_b),
        .en_rem   (z_en_rem),
        .sel_mux3 (z_sel_mux3),
        .sel_mux4 (z_sel_mux4),
        .busy     (z_busy),
        .done     (z_done),
        .iter_cnt (z_iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit s;
        bit a;
        int st;
        int it;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Nominal ITERS = 3 sequence after start: cycles 1..10.
    int nst[10] = '{ST_INIT_N, ST_INIT_D, ST_ITER_N, ST_ITER_D, ST_ITER_N,
                    ST_ITER_D, ST_ITER_N, ST_ITER_D, ST_REM, ST_DONE};
    int nit[10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};

    // {en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, done}
    function automatic logic [8:0] exp_of(int st, bit stalled);
        logic [8:0] v;
        case (st)
            ST_INIT_N: v = 9'b1_0_0_00_00_1_0;
            ST_INIT_D: v = 9'b0_1_0_00_01_1_0;
            ST_ITER_N: v = 9'b1_0_0_01_10_1_0;
            ST_ITER_D: v = 9'b0_1_0_01_11_1_0;
            ST_REM:    v = 9'b0_0_1_10_10_1_0;
            ST_DONE:   v = 9'b0_0_0_00_00_0_1;
            default:   v = 9'b0_0_0_00_00_0_0;
        endcase
        if (stalled) v[8:6] = 3'b000;
        return v;
    endfunction

    function automatic logic [12:0] act_main();
        return {en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, done, iter_cnt};
    endfunction

    function automatic logic [12:0] act_zero();
        return {z_en_a, z_en_b, z_en_rem, z_sel_mux3, z_sel_mux4, z_busy, z_done, z_iter_cnt};
    endfunction

    task automatic check(input string name, input logic [12:0] act,
                         input int st, input int it, input bit stalled);
        logic [12:0] expv;
        logic [3:0]  it4;
        it4  = it[3:0];
        expv = {exp_of(st, stalled), it4};
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got {en_a,en_b,en_rem,s3,s4,busy,done,iter}=%b expected %b",
                     name, $time, act, expv);
        end
    endtask

    task automatic add(input bit s, input bit a, input int st, input int it);
        vec_t v;
        v.s = s; v.a = a; v.st = st; v.it = it;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, then settle away from the edge.
    task automatic step(input bit s, input bit a, input bit s0);
        start  = s;
        abort  = a;
        start0 = s0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // nominal single start
        for (int k = 0; k < 10; k++) add(k == 0, 1'b0, nst[k], nit[k]);
        add(1'b0, 1'b0, ST_IDLE, 2);
        // start pulses during busy cycles 3..8 are ignored
        for (int k = 0; k < 10; k++) add((k == 0) || (k >= 2 && k <= 7), 1'b0, nst[k], nit[k]);
        add(1'b0, 1'b0, ST_IDLE, 2);
        // start held high: back-to-back issue, done every 10 cycles
        for (int k = 0; k < 20; k++) add(1'b1, 1'b0, nst[k % 10], nit[k % 10]);
        add(1'b0, 1'b0, ST_IDLE, 2);
        // abort during ITER_D with iter_cnt = 1
        for (int k = 0; k < 6; k++) add(k == 0, 1'b0, nst[k], nit[k]);
        add(1'b0, 1'b1, ST_IDLE, 0);
        for (int k = 0; k < 4; k++) add(1'b0, 1'b0, ST_IDLE, 0);
        // start and abort together in DONE: abort wins
        for (int k = 0; k < 10; k++) add(k == 0, 1'b0, nst[k], nit[k]);
        add(1'b1, 1'b1, ST_IDLE, 0);
        add(1'b0, 1'b0, ST_IDLE, 0);

        // ---------------- reset and idle ----------------
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("reset_hold", act_main(), ST_IDLE, 0, 1'b0);
            check("reset_hold_i0", act_zero(), ST_IDLE, 0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle", act_main(), ST_IDLE, 0, 1'b0);
        end

        // ---------------- table-driven run ----------------
        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].a, 1'b0);
            check($sformatf("vec%0d", i), act_main(), vecs[i].st, vecs[i].it, 1'b0);
        end

        // ---------------- ITERS = 0 instance ----------------
        step(1'b0, 1'b0, 1'b1);
        check("i0_init_n", act_zero(), ST_INIT_N, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("i0_init_d", act_zero(), ST_INIT_D, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("i0_rem", act_zero(), ST_REM, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("i0_done", act_zero(), ST_DONE, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("i0_idle", act_zero(), ST_IDLE, 0, 1'b0);

        // ---------------- async reset mid-operation ----------------
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 1'b0, 1'b0);
            check("pre_rst", act_main(), nst[k], nit[k], 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", act_main(), ST_IDLE, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check("first_start", act_main(), ST_INIT_N, 0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("after_rst", act_main(), nst[k], nit[k], 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("after_rst_idle", act_main(), ST_IDLE, 2, 1'b0);

`ifdef FPDIV_CTRL_STALL_EN
        // ---------------- stall for 2 cycles in ITER_N ----------------
        for (int k = 0; k < 3; k++) begin
            step(k == 0, 1'b0, 1'b0);
            check("pre_stall", act_main(), nst[k], nit[k], 1'b0);
        end
        stall = 1'b1;
        #1;
        check("stall_c3", act_main(), ST_ITER_N, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("stall_c4", act_main(), ST_ITER_N, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        #1;
        check("stall_c5", act_main(), ST_ITER_N, 0, 1'b0);
        for (int k = 3; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("stall_c%0d", k + 3), act_main(), nst[k], nit[k], 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("stall_idle", act_main(), ST_IDLE, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Sequencing FSM for the Goldschmidt single-precision divider datapath.
- Drives that datapath's register enables (en_a, en_b, en_rem) and multiplier operand selects (sel_mux3, sel_mux4) through: initial-approximation multiplies, ITERS refinement iterations, and the remainder multiply.
- Exposes a start/busy/done handshake to the issuing FP unit; done marks the cycle in which the datapath's final_ans is valid.

Parameters:
- ITERS, 3, number of Goldschmidt refinement iterations (each = one numerator step + one denominator step); legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a division; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel; returns the FSM to IDLE, no done.
- en_a  output  1  rega (quotient path) load enable.
- en_b  output  1  regb/regc (denominator path) load enable.
- en_rem  output  1  remainder register load enable.
- sel_mux3  output  2  multiplier operand A select: 0 = initial approx, 1 = regc (2-D), 2 = denom.
- sel_mux4  output  2  multiplier operand B select: 0 = num, 1 = denom, 2 = rega, 3 = regb.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse; final_ans is valid this cycle.
- iter_cnt  output  4  current iteration index, for debug/observation.

Behaviour:
- States, encoded one per cycle: IDLE, INIT_N, INIT_D, ITER_N, ITER_D, REM, DONE.
- All outputs are Moore (decoded from registered state).
- Per-state outputs as (en_a, en_b, en_rem, sel_mux3, sel_mux4):
  - IDLE: 0,0,0,0,0
  - INIT_N: 1,0,0,0,0 (approx*num -> rega)
  - INIT_D: 0,1,0,0,1 (approx*denom -> regb, regc)
  - ITER_N: 1,0,0,1,2 (regc*rega -> rega)
  - ITER_D: 0,1,0,1,3 (regc*regb -> regb, regc)
  - REM: 0,0,1,2,2 (denom*rega -> remainder register)
  - DONE: 0,0,0,0,0 with done = 1
- Transitions:
  - IDLE: start -> INIT_N, else stay.
  - INIT_N -> INIT_D.
  - INIT_D -> ITER_N if ITERS > 0, else REM.
  - ITER_N -> ITER_D.
  - ITER_D -> ITER_N if iter_cnt < ITERS-1, else REM. iter_cnt increments on the ITER_D -> ITER_N transition.
  - REM -> DONE.
  - DONE: start -> INIT_N (back-to-back issue), else IDLE.
- iter_cnt clears to 0 on entry to INIT_N.
- Latency: start sampled at edge E0 -> done high in the cycle following edge E0 + 3 + 2*ITERS. ITERS = 3 gives 9 cycles after E0. Initiation interval = 4 + 2*ITERS cycles.
- start while busy: ignored; no queueing.
- abort: highest priority in all states except IDLE; next state IDLE, iter_cnt 0, done never asserted for that operation. If start and abort are both high in DONE, abort wins (-> IDLE).
- Reset (asynchronous assert, any state including mid-operation):
  - state = IDLE, iter_cnt = 0.
  - All enables 0, sel_mux3 = 0, sel_mux4 = 0, busy = 0, done = 0.
  - Deassertion is assumed synchronised externally. The first start is honoured on the first edge after release.
- In non-enable states the datapath registers hold, so no enable is ever asserted while the FSM is in IDLE or DONE.

Optional Feature:
- Macro: FPDIV_CTRL_STALL_EN.
- When defined:
  - Adds input port stall (1 bit).
  - While stall = 1 in any busy state: state and iter_cnt hold, en_a/en_b/en_rem are forced 0, and sel_mux3/sel_mux4 keep their state-decoded values.
  - stall has no effect in IDLE or DONE. abort and reset override stall.
- When undefined: no stall port; the FSM advances every cycle.

Test Plan:
- Reset and idle:
  - Hold reset = 0 for 3 cycles, release, then keep start = 0 for 5 cycles.
  - Required: all outputs stay 0 and state stays IDLE.
- Nominal sequence, ITERS = 3:
  - Pulse start for 1 cycle at edge E0.
  - Required: en_a high at cycles 1, 3, 5, 7; en_b high at cycles 2, 4, 6, 8; en_rem high at cycle 9 with sel_mux3 = 2 and sel_mux4 = 2; done high at cycle 10 only; busy high at cycles 1–9.
- ITERS = 0 build:
  - Start.
  - Required: INIT_N, INIT_D, REM, DONE; done at cycle 4.
- Back-to-back and ignored start:
  - Hold start high continuously.
  - Required: done every 10 cycles. start pulses during busy cycles 3–8 cause no restart and no change to the sequence.
- Abort and async reset mid-operation:
  - Assert abort in the ITER_D cycle with iter_cnt = 1.
  - Required: next cycle IDLE, no done, iter_cnt = 0.
  - Repeat with reset asserted mid-cycle: outputs go to 0 immediately, without waiting for a clock edge.
- Stall (FPDIV_CTRL_STALL_EN defined):
  - stall = 1 for 2 cycles during ITER_N.
  - Required: en_a = 0 while stalled with sel_mux3 = 1 and sel_mux4 = 2 held; done delayed to cycle 12.
